// File: rtl/veririsc_pkg.sv
// veririsc_pkg: shared constants and helpers for the VeriRISC controller.
//   - OP_*  : 3-bit opcode encodings of the IR opcode field
//   - PH_*  : 3-bit phase encodings of the 8-phase instruction cycle
//   - ctrl_strobes_t : bundle of datapath strobes produced by the decoder
//   - is_aluop() : true for opcodes that read memory and load the accumulator
package veririsc_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic wr;
    logic data_e;
  } ctrl_strobes_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/controller_if.sv
// controller_if: bundles the controller's run-control inputs and datapath strobes.
//   Inputs to controller : ce, opcode[2:0], zero, step (only with CONTROLLER_STEP_EN)
//   Outputs of controller: sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt, phase[2:0]
// Modports: slave = controller side, master = the driver of ce/opcode/zero (core or bench).
// There is no valid/ready handshake here: ce is a level enable sampled on every rising
// edge, and the strobes are level signals valid in the cycle of the phase they decode.
interface controller_if;
  logic       ce;
  logic [2:0] opcode;
  logic       zero;
`ifdef CONTROLLER_STEP_EN
  logic       step;
`endif
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       ld_ac;
  logic       ld_pc;
  logic       inc_pc;
  logic       wr;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport slave (
    input  ce, opcode, zero,
`ifdef CONTROLLER_STEP_EN
    input  step,
`endif
    output sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt, phase
  );

  modport master (
    output ce, opcode, zero,
`ifdef CONTROLLER_STEP_EN
    output step,
`endif
    input  sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt, phase
  );
endinterface

// File: rtl/controller_decode.sv
// ctrl_decode: purely combinational strobe decoder.
//   phase_i[2:0]  current registered phase
//   opcode_i[2:0] live IR opcode
//   zero_i        ALU zero flag (only consulted in PH_ALU_OP)
//   halted_i      controller is halted; forces every strobe to 0
//   strobes_o     decoded datapath strobes
module ctrl_decode
  import veririsc_pkg::*;
(
  input  logic [2:0]    phase_i,
  input  logic [2:0]    opcode_i,
  input  logic          zero_i,
  input  logic          halted_i,
  output ctrl_strobes_t strobes_o
);

  logic alu_op;
  logic op_skz;
  logic op_sto;
  logic op_jmp;

  assign alu_op = is_aluop(opcode_i);
  assign op_skz = (opcode_i == OP_SKZ);
  assign op_sto = (opcode_i == OP_STO);
  assign op_jmp = (opcode_i == OP_JMP);

  always_comb begin
    strobes_o = '0;
    if (!halted_i) begin
      // Address mux points at the PC for the whole fetch half of the cycle.
      strobes_o.sel = (phase_i <= PH_IDLE);
      case (phase_i)
        PH_INST_ADDR: ;
        PH_INST_FETCH: strobes_o.rd = 1'b1;
        PH_INST_LOAD, PH_IDLE: begin
          strobes_o.rd    = 1'b1;
          strobes_o.ld_ir = 1'b1;
        end
        PH_OP_ADDR: strobes_o.inc_pc = 1'b1;
        PH_OP_FETCH: strobes_o.rd = alu_op;
        PH_ALU_OP: begin
          strobes_o.rd     = alu_op;
          // Skip-if-zero: second increment steps over the next instruction.
          strobes_o.inc_pc = op_skz & zero_i;
          strobes_o.ld_pc  = op_jmp;
          strobes_o.data_e = op_sto;
        end
        PH_STORE: begin
          strobes_o.rd     = alu_op;
          strobes_o.inc_pc = op_jmp;
          strobes_o.ld_pc  = op_jmp;
          strobes_o.ld_ac  = alu_op;
          strobes_o.data_e = op_sto;
          strobes_o.wr     = op_sto;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/controller.sv
// controller: VeriRISC instruction sequencer (8-phase cycle per instruction).
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (wins over ce and step)
//   bus  - controller_if.slave: ce/opcode/zero(/step) in, strobes/halt/phase out
// Optional feature macro: CONTROLLER_STEP_EN adds bus.step, which releases a HALTED
// controller into phase 5 so HLT acts as a breakpoint. Without it, HALTED is terminal.
// State: phase_q (the 8-state phase FSM, visible on bus.phase) and halted_q (bus.halt).
module controller
  import veririsc_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int PHASE_W  = 3
) (
  input  logic clk,
  input  logic rst,
  controller_if.slave bus
);

  if (OPCODE_W != 3 || PHASE_W != 3) begin : g_bad_width
    $error("controller: OPCODE_W and PHASE_W must both be 3");
  end

  logic [2:0]    phase_q, phase_d;
  logic          halted_q, halted_d;
  ctrl_strobes_t strobes;

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
`ifdef CONTROLLER_STEP_EN
      // PC was already incremented in phase 4, so resume at the operand fetch.
      if (bus.step) begin
        halted_d = 1'b0;
        phase_d  = PH_OP_FETCH;
      end
`endif
    end else if (bus.ce) begin
      if (phase_q == PH_OP_ADDR && bus.opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  ctrl_decode u_decode (
    .phase_i   (phase_q),
    .opcode_i  (bus.opcode),
    .zero_i    (bus.zero),
    .halted_i  (halted_q),
    .strobes_o (strobes)
  );

  assign bus.sel    = strobes.sel;
  assign bus.rd     = strobes.rd;
  assign bus.ld_ir  = strobes.ld_ir;
  assign bus.ld_ac  = strobes.ld_ac;
  assign bus.ld_pc  = strobes.ld_pc;
  assign bus.inc_pc = strobes.inc_pc;
  assign bus.wr     = strobes.wr;
  assign bus.data_e = strobes.data_e;
  assign bus.halt   = halted_q;
  assign bus.phase  = phase_q;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller. Strobe vectors are packed in the order
// {sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e}; per-strobe expectations are
// hand-written 8-bit phase masks (bit p = strobe high in phase p).
module tb_controller;
  import veririsc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  controller_if bus ();

  controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs_vec();
    return {bus.sel, bus.rd, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.wr, bus.data_e};
  endfunction

  // Builds the expected strobe vector for phase p from per-strobe phase masks.
  function automatic logic [7:0] pick(input logic [7:0] m_sel, input logic [7:0] m_rd,
                                      input logic [7:0] m_ir, input logic [7:0] m_ac,
                                      input logic [7:0] m_pc, input logic [7:0] m_inc,
                                      input logic [7:0] m_wr, input logic [7:0] m_de,
                                      input int p);
    return {m_sel[p], m_rd[p], m_ir[p], m_ac[p], m_pc[p], m_inc[p], m_wr[p], m_de[p]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.opcode = OP_ADD;
    bus.zero = 1'b0;
`ifdef CONTROLLER_STEP_EN
    bus.step = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.phase !== 3'd0 || bus.halt !== 1'b0) begin
      failures++;
      $display("FAIL reset_state phase=%0d halt=%b exp phase=0 halt=0", bus.phase, bus.halt);
    end
    checks++;
    if (obs_vec() !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=%b", obs_vec(), 8'b1000_0000);
    end
  endtask

  task automatic test_count();
    bus.ce = 1'b1;
    bus.opcode = OP_ADD;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (bus.phase !== 3'(p) || bus.sel !== (p < 4)) begin
        failures++;
        $display("FAIL count phase=%0d sel=%b exp phase=%0d sel=%b", bus.phase, bus.sel, p, (p < 4));
      end
      tick();
    end
    checks++;
    if (bus.phase !== 3'd0) begin
      failures++;
      $display("FAIL count_wrap phase=%0d exp=0", bus.phase);
    end
  endtask

  task automatic test_add();
    logic [7:0] e;
    bus.ce = 1'b1;
    bus.opcode = OP_ADD;
    bus.zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      e = pick(8'h0F, 8'hEE, 8'h0C, 8'h80, 8'h00, 8'h10, 8'h00, 8'h00, p);
      checks++;
      if (bus.phase !== 3'(p) || obs_vec() !== e) begin
        failures++;
        $display("FAIL add phase=%0d got=%b exp=%b", bus.phase, obs_vec(), e);
      end
      tick();
    end
  endtask

  task automatic test_skz();
    logic [7:0] e;
    logic [7:0] inc_m;
    bus.ce = 1'b1;
    bus.opcode = OP_SKZ;
    for (int z = 1; z >= 0; z--) begin
      bus.zero = z[0];
      inc_m = z[0] ? 8'h50 : 8'h10;
      for (int p = 0; p < 8; p++) begin
        e = pick(8'h0F, 8'h0E, 8'h0C, 8'h00, 8'h00, inc_m, 8'h00, 8'h00, p);
        checks++;
        if (bus.phase !== 3'(p) || obs_vec() !== e) begin
          failures++;
          $display("FAIL skz zero=%0d phase=%0d got=%b exp=%b", z, bus.phase, obs_vec(), e);
        end
        tick();
      end
    end
  endtask

  task automatic test_sto_jmp();
    logic [7:0] e;
    bus.ce = 1'b1;
    bus.zero = 1'b1;
    bus.opcode = OP_STO;
    for (int p = 0; p < 8; p++) begin
      e = pick(8'h0F, 8'h0E, 8'h0C, 8'h00, 8'h00, 8'h10, 8'h80, 8'hC0, p);
      checks++;
      if (bus.phase !== 3'(p) || obs_vec() !== e) begin
        failures++;
        $display("FAIL sto phase=%0d got=%b exp=%b", bus.phase, obs_vec(), e);
      end
      tick();
    end
    bus.opcode = OP_JMP;
    for (int p = 0; p < 8; p++) begin
      e = pick(8'h0F, 8'h0E, 8'h0C, 8'h00, 8'hC0, 8'h90, 8'h00, 8'h00, p);
      checks++;
      if (bus.phase !== 3'(p) || obs_vec() !== e) begin
        failures++;
        $display("FAIL jmp phase=%0d got=%b exp=%b", bus.phase, obs_vec(), e);
      end
      tick();
    end
  endtask

  // Runs from phase 0 up to phase 4 with HLT and takes the halting edge.
  task automatic run_to_halt();
    bus.ce = 1'b1;
    bus.opcode = OP_HLT;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.phase !== 3'd4 || bus.halt !== 1'b0 || obs_vec() !== 8'b0000_0100) begin
      failures++;
      $display("FAIL hlt_phase4 phase=%0d halt=%b got=%b exp phase=4 halt=0 strobes=00000100",
               bus.phase, bus.halt, obs_vec());
    end
    tick();
  endtask

  task automatic test_halt();
    run_to_halt();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.phase !== 3'd4 || bus.halt !== 1'b1 || obs_vec() !== 8'h00) begin
        failures++;
        $display("FAIL halted cyc=%0d phase=%0d halt=%b got=%b exp phase=4 halt=1 strobes=00000000",
                 i, bus.phase, bus.halt, obs_vec());
      end
      bus.ce = 1'($urandom_range(0, 1));
      bus.opcode = 3'($urandom_range(0, 7));
      bus.zero = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1;
    bus.ce = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.phase !== 3'd0 || bus.halt !== 1'b0 || obs_vec() !== 8'b1000_0000) begin
      failures++;
      $display("FAIL halt_reset phase=%0d halt=%b got=%b exp phase=0 halt=0 strobes=10000000",
               bus.phase, bus.halt, obs_vec());
    end
  endtask

`ifdef CONTROLLER_STEP_EN
  task automatic test_step();
    run_to_halt();
    bus.step = 1'b1;
    tick();
    checks++;
    if (bus.phase !== 3'd5 || bus.halt !== 1'b0) begin
      failures++;
      $display("FAIL step_resume phase=%0d halt=%b exp phase=5 halt=0", bus.phase, bus.halt);
    end
    // step held while running must not disturb normal advance.
    bus.opcode = OP_ADD;
    tick();
    checks++;
    if (bus.phase !== 3'd6 || bus.halt !== 1'b0) begin
      failures++;
      $display("FAIL step_ignored phase=%0d halt=%b exp phase=6 halt=0", bus.phase, bus.halt);
    end
    bus.step = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.phase !== 3'd0) begin
      failures++;
      $display("FAIL step_wrap phase=%0d exp=0", bus.phase);
    end
  endtask
`endif

  task automatic test_ce_hold();
    bus.ce = 1'b1;
    bus.opcode = OP_JMP;
    for (int i = 0; i < 6; i++) tick();
    bus.ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.phase !== 3'd6 || bus.ld_pc !== 1'b1) begin
        failures++;
        $display("FAIL ce_hold cyc=%0d phase=%0d ld_pc=%b exp phase=6 ld_pc=1", i, bus.phase, bus.ld_pc);
      end
    end
    bus.ce = 1'b1;
    tick();
    checks++;
    if (bus.phase !== 3'd7 || bus.ld_pc !== 1'b1 || bus.inc_pc !== 1'b1) begin
      failures++;
      $display("FAIL ce_resume phase=%0d ld_pc=%b inc_pc=%b exp phase=7 ld_pc=1 inc_pc=1",
               bus.phase, bus.ld_pc, bus.inc_pc);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    test_reset();
    test_count();
    test_add();
    test_skz();
    test_sto_jmp();
    test_halt();
`ifdef CONTROLLER_STEP_EN
    test_step();
`endif
    test_ce_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
